// File: rtl/pipe_adder_arbiter_pkg.sv
// Shared types for the two-requester arbiter in front of an external pipelined adder.
package pipe_adder_arbiter_pkg;

  localparam int W_DEF   = 4;
  localparam int LAT_DEF = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: REQ0};

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/pipe_adder_arbiter_tag_pipe.sv
// LAT-deep shift register of {valid, id} tags, aligned with the external adder's latency.
module adder_tag_pipe
  import pipe_adder_arbiter_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [LAT];

  // NOTE: every stage is reset, not just the valid bits at the output: a stale
  // valid left in any stage would surface as a phantom response after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) stage_q[k] <= TAG_IDLE;
    end else begin
      stage_q[0] <= tag_i;
      for (int k = 1; k < LAT; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/pipe_adder_arbiter.sv
// Round-robin arbiter and operand mux sharing one external pipelined adder between
// two requesters; completing results are steered back by a tag pipeline.
module pipe_adder_arbiter
  import pipe_adder_arbiter_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_ci,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_ci,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W:0]   rsp_sum,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_ci,
  input  logic [W-1:0] add_s,
  input  logic         add_co
);

  req_id_e last_q, last_d;
  req_id_e pref;
  logic    grant0, grant1;
  tag_t    tag_in, tag_out;

  assign pref = other_id(last_q);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches leaves a signal unassigned and infers a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && en) begin
      if (req0_valid && req1_valid) begin
        grant0 = (pref == REQ0);
        grant1 = (pref == REQ1);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    last_d = last_q;
    if (grant0)      last_d = REQ0;
    else if (grant1) last_d = REQ1;
  end

  // Reset to "last granted = 1" so requester 0 wins the first contended cycle.
  // NOTE: state registers use non-blocking assignment so all flops update
  // together at the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= REQ1;
    else     last_q <= last_d;
  end

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (grant0) begin
      add_a  = req0_a;
      add_b  = req0_b;
      add_ci = req0_ci;
    end else if (grant1) begin
      add_a  = req1_a;
      add_b  = req1_b;
      add_ci = req1_ci;
    end
  end

  always_comb begin
    tag_in       = TAG_IDLE;
    tag_in.valid = grant0 | grant1;
    tag_in.id    = grant1 ? REQ1 : REQ0;
  end

  adder_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign rsp0_valid = tag_out.valid && (tag_out.id == REQ0);
  assign rsp1_valid = tag_out.valid && (tag_out.id == REQ1);
  assign rsp_sum    = tag_out.valid ? {add_co, add_s} : '0;

endmodule
